regfile_hazard_ctrl: RTL and testbench

- Hazard and writeback sequencer for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB) built around the 16-entry, 5-bit-addressed register file.
- Tracks destination records for the EX, MEM and WB slots and detects load-use hazards. It stalls ID, applies branch flushes and drives EX operand-forwarding selects.
- Drives the register file write enable and write address.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/hazard_fwd_sel.sv | 21 ++
 rtl/regfile_hazard_ctrl.sv | 94 +++++++++
 tb/tb_regfile_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-address sizing, forwarding selects and pipeline slot record
package cpu_pkg;

   localparam int AW   = 5;
   localparam int NREG = 16;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic          valid;
      logic          we;
      logic [AW-1:0] waddr;
      logic          is_load;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          use_rs;
      logic          use_rt;
   } stage_t;

   // r0 is hardwired and addresses past the implemented file have no storage, so neither counts as a result
   function automatic logic is_writer(input stage_t s);
      return s.valid & s.we & (s.waddr != '0) & (s.waddr < AW'(NREG));
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: picks the EX operand source, preferring the younger MEM result over WB
module hazard_fwd_sel
   import cpu_pkg::*;
(
   input  logic          i_ex_valid,
   input  logic          i_use,
   input  logic [AW-1:0] i_src,
   input  logic          i_mem_wr,
   input  logic [AW-1:0] i_mem_waddr,
   input  logic          i_wb_wr,
   input  logic [AW-1:0] i_wb_waddr,
   output logic [1:0]    o_sel
);

   logic w_rd;

   assign w_rd  = i_ex_valid & i_use;
   assign o_sel = (w_rd & i_mem_wr & (i_mem_waddr == i_src)) ? FWD_MEM :
                  (w_rd & i_wb_wr  & (i_wb_waddr  == i_src)) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/regfile_hazard_ctrl.sv
// regfile_hazard_ctrl: load-use stall, branch flush, EX forwarding and regfile writeback sequencing
module regfile_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_we,
   input  logic [AW-1:0]    id_waddr,
   input  logic             id_is_load,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             wb_we,
   output logic [AW-1:0]    wb_waddr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   stage_t           r_ex, r_mem, r_wb;
   stage_t           w_id;
   logic             w_haz, w_mem_wr, w_unused;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   assign w_id = '{valid: id_valid, we: id_we, waddr: id_waddr, is_load: id_is_load,
                   rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt};

   // a load in EX has no result until after MEM, so a dependent ID instruction must wait one cycle
   assign w_haz = id_valid & is_writer(r_ex) & r_ex.is_load &
                  ((id_use_rs & (id_rs == r_ex.waddr)) | (id_use_rt & (id_rt == r_ex.waddr)));

   assign stall     = w_haz & ~flush;
   assign w_mem_wr  = is_writer(r_mem);
   assign wb_we     = is_writer(r_wb);
   assign wb_waddr  = wb_we ? r_wb.waddr : '0;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
   assign w_unused  = ^{r_mem.is_load, r_mem.rs, r_mem.rt, r_mem.use_rs, r_mem.use_rt,
                        r_wb.is_load, r_wb.rs, r_wb.rt, r_wb.use_rs, r_wb.use_rt};

   // slot shift: killed, stalled or empty ID slots enter EX as bubbles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         r_ex  <= (flush | w_haz | ~id_valid) ? '0 : w_id;
      end
   end

   // saturating event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   hazard_fwd_sel u_fwd_a (
      .i_ex_valid  (r_ex.valid),
      .i_use       (r_ex.use_rs),
      .i_src       (r_ex.rs),
      .i_mem_wr    (w_mem_wr),
      .i_mem_waddr (r_mem.waddr),
      .i_wb_wr     (wb_we),
      .i_wb_waddr  (r_wb.waddr),
      .o_sel       (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .i_ex_valid  (r_ex.valid),
      .i_use       (r_ex.use_rt),
      .i_src       (r_ex.rt),
      .i_mem_wr    (w_mem_wr),
      .i_mem_waddr (r_mem.waddr),
      .i_wb_wr     (wb_we),
      .i_wb_waddr  (r_wb.waddr),
      .o_sel       (fwd_b)
   );

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// tb_regfile_hazard_ctrl: directed scenarios with a writeback scoreboard
module tb_regfile_hazard_ctrl;
   import cpu_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          id_valid, id_use_rs, id_use_rt, id_we, id_is_load, flush;
   logic [AW-1:0] id_rs, id_rt, id_waddr;
   logic          stall, wb_we;
   logic [1:0]    fwd_a, fwd_b;
   logic [AW-1:0] wb_waddr;
   logic [15:0]   stall_cnt, flush_cnt;

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
   } wb_exp_t;

   wb_exp_t sb[$];
   int      compared   = 0;
   int      mismatched = 0;
   int      cyc        = 0;
   bit      mon_en     = 1'b0;

   regfile_hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_waddr(id_waddr),
      .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
      $fatal(1);
   end

   // scoreboard consumer: every cycle wb must match the head entry when it is due, else be idle
   always @(negedge clk) begin
      if (mon_en) begin
         compared++;
         if (sb.size() != 0 && sb[0].due == cyc) begin
            if (wb_we !== 1'b1 || wb_waddr !== sb[0].addr) begin
               mismatched++;
               $display("FAIL wb_write cyc=%0d: got we=%b addr=%0d, expected we=1 addr=%0d", cyc, wb_we, wb_waddr, sb[0].addr);
            end
            void'(sb.pop_front());
         end else if (wb_we !== 1'b0 || wb_waddr !== '0) begin
            mismatched++;
            $display("FAIL wb_idle cyc=%0d: got we=%b addr=%0d, expected we=0 addr=0", cyc, wb_we, wb_waddr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [AW-1:0] wa, input logic ld, input logic fl);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_we = we; id_waddr = wa; id_is_load = ld; flush = fl;
   endtask

   task automatic nop();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic expect_wb(input logic [AW-1:0] a);
      sb.push_back('{cyc + 3, a});
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), AW'($urandom), 1'($urandom), 1'($urandom));
         @(negedge clk);
         compared++;
         if ({stall, fwd_a, fwd_b, wb_we, wb_waddr, stall_cnt, flush_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_hold: got stall=%b fa=%b fb=%b we=%b wa=%0d sc=%0d fc=%0d, expected all 0",
                     stall, fwd_a, fwd_b, wb_we, wb_waddr, stall_cnt, flush_cnt);
         end
         tick();
      end
      nop();
      @(negedge clk);
      #1 rst = 1'b1;
      mon_en = 1'b1;
      tick();
      @(negedge clk);
      compared++;
      if ({stall, fwd_a, fwd_b, wb_we, wb_waddr, stall_cnt, flush_cnt} !== '0) begin
         mismatched++;
         $display("FAIL reset_release: got stall=%b fa=%b fb=%b sc=%0d fc=%0d, expected all 0",
                  stall, fwd_a, fwd_b, stall_cnt, flush_cnt);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 2, 1, 1, 1, 3, 0, 0);
      expect_wb(3);
      @(negedge clk);
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL b2b_no_stall: got %b expected 0", stall); end
      tick();
      drive(1, 3, 4, 1, 1, 1, 6, 0, 0);
      expect_wb(6);
      @(negedge clk);
      compared++;
      if (fwd_a !== FWD_RF) begin mismatched++; $display("FAIL b2b_fwd_rf: got %b expected %b", fwd_a, FWD_RF); end
      tick();
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      compared++;
      if (fwd_a !== FWD_MEM) begin mismatched++; $display("FAIL b2b_fwd_mem: got %b expected %b", fwd_a, FWD_MEM); end
      compared++;
      if (fwd_b !== FWD_RF) begin mismatched++; $display("FAIL b2b_fwd_b_rf: got %b expected %b", fwd_b, FWD_RF); end
      tick();
      nop();
      @(negedge clk);
      compared++;
      if (fwd_a !== FWD_WB) begin mismatched++; $display("FAIL b2b_fwd_wb: got %b expected %b", fwd_a, FWD_WB); end
      tick();
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
      expect_wb(3);
      tick();
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
      expect_wb(3);
      tick();
      drive(1, 3, 3, 1, 1, 0, 0, 0, 0);
      tick();
      nop();
      @(negedge clk);
      compared++;
      if (fwd_a !== FWD_MEM) begin mismatched++; $display("FAIL prio_fwd_a: got %b expected %b", fwd_a, FWD_MEM); end
      compared++;
      if (fwd_b !== FWD_MEM) begin mismatched++; $display("FAIL prio_fwd_b: got %b expected %b", fwd_b, FWD_MEM); end
      tick();
      repeat (4) tick();
   endtask

   task automatic test_load_use();
      drive(1, 1, 0, 1, 0, 1, 5, 1, 0);
      expect_wb(5);
      @(negedge clk);
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL lu_load_issue: stall=%b expected 0", stall); end
      tick();
      drive(1, 0, 5, 0, 1, 1, 7, 0, 0);
      @(negedge clk);
      compared++;
      if (stall !== 1'b1) begin mismatched++; $display("FAIL lu_stall: got %b expected 1", stall); end
      tick();
      @(negedge clk);
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL lu_one_cycle: stall=%b expected 0", stall); end
      compared++;
      if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
      compared++;
      if (fwd_b !== FWD_RF) begin mismatched++; $display("FAIL lu_bubble: fwd_b=%b expected %b", fwd_b, FWD_RF); end
      expect_wb(7);
      tick();
      nop();
      @(negedge clk);
      compared++;
      if (fwd_b !== FWD_WB) begin mismatched++; $display("FAIL lu_fwd_wb: got %b expected %b", fwd_b, FWD_WB); end
      tick();
      repeat (4) tick();
   endtask

   task automatic test_flush_vs_stall();
      drive(1, 1, 0, 1, 0, 1, 5, 1, 0);
      expect_wb(5);
      tick();
      drive(1, 0, 5, 0, 1, 1, 9, 0, 1);
      @(negedge clk);
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL fl_no_stall: got %b expected 0", stall); end
      tick();
      nop();
      @(negedge clk);
      compared++;
      if (flush_cnt !== 16'd1) begin mismatched++; $display("FAIL fl_flush_cnt: got %0d expected 1", flush_cnt); end
      compared++;
      if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL fl_stall_cnt: got %0d expected 1", stall_cnt); end
      compared++;
      if (fwd_b !== FWD_RF) begin mismatched++; $display("FAIL fl_bubble: fwd_b=%b expected %b", fwd_b, FWD_RF); end
      tick();
      repeat (4) tick();
   endtask

   task automatic test_reg_bounds();
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
      tick();
      drive(1, 0, 0, 1, 1, 1, 20, 1, 0);
      @(negedge clk);
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL rb_r0_stall: got %b expected 0", stall); end
      tick();
      drive(1, 20, 20, 1, 1, 0, 0, 0, 0);
      @(negedge clk);
      compared++;
      if (stall !== 1'b0) begin mismatched++; $display("FAIL rb_r20_stall: got %b expected 0", stall); end
      compared++;
      if ({fwd_a, fwd_b} !== {FWD_RF, FWD_RF}) begin mismatched++; $display("FAIL rb_r0_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); end
      tick();
      nop();
      @(negedge clk);
      compared++;
      if ({fwd_a, fwd_b} !== {FWD_RF, FWD_RF}) begin mismatched++; $display("FAIL rb_r20_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); end
      compared++;
      if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL rb_stall_cnt: got %0d expected 1", stall_cnt); end
      tick();
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
      expect_wb(1);
      tick();
      drive(1, 0, 0, 0, 0, 1, 2, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 1, 4, 0, 0);
      tick();
      nop();
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      sb.delete();
      rst = 1'b0;
      #1;
      compared++;
      if (wb_we !== 1'b0 || wb_waddr !== '0) begin
         mismatched++;
         $display("FAIL mid_reset_async: got we=%b addr=%0d expected 0/0", wb_we, wb_waddr);
      end
      compared++;
      if ({stall_cnt, flush_cnt} !== '0) begin
         mismatched++;
         $display("FAIL mid_reset_cnt: got sc=%0d fc=%0d expected 0/0", stall_cnt, flush_cnt);
      end
      tick();
      repeat (2) tick();
      @(negedge clk);
      #1 rst = 1'b1;
      mon_en = 1'b1;
      repeat (6) tick();
   endtask

   initial begin
      nop();
      test_reset();
      test_back_to_back();
      test_load_use();
      test_flush_vs_stall();
      test_reg_bounds();
      test_reset_mid();
      mon_en = 1'b0;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL sb_drain: %0d writebacks never seen, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
